// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown timer: set/run/pause/alarm FSM with a one-second prescaler
// and an alarm that clears itself after ALARM_SEC seconds.
module bcd_countdown_timer #(
    parameter int CLK_PER_SEC = 100000000,
    parameter int MAX_MIN     = 99,
    parameter int ALARM_SEC   = 5
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        start_stop_pe,
    input  logic        inc_sec_pe,
    input  logic        inc_min_pe,
    input  logic        clear_pe,
    input  logic        alarm_ack,
    output logic [15:0] set_time,
    output logic [15:0] count_time,
    output logic [15:0] value,
    output logic [1:0]  state,
    output logic        alarm
);

    typedef enum logic [1:0] {
        S_SET   = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_e;

    localparam int PW = $clog2(CLK_PER_SEC);
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_SEC - 1);
    localparam logic [AW-1:0] ALARM_LAST  = AW'(ALARM_SEC - 1);
    localparam logic [7:0]    MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    state_e        state_q, state_d;
    logic [15:0]   set_d, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          tick;

    // BCD order matches unsigned order, so a plain >= finds the wrap point.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] last);
        if (v >= last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_dec_sec(input logic [15:0] t);
        logic [7:0] m;
        logic [7:0] s;
        m = t[15:8];
        s = t[7:0];
        if (t == 16'h0000)
            return 16'h0000;
        if (s == 8'h00) begin
            s = 8'h59;
            m = (m[3:0] == 4'd0) ? {m[7:4] - 4'd1, 4'd9} : {m[7:4], m[3:0] - 4'd1};
        end else begin
            s = (s[3:0] == 4'd0) ? {s[7:4] - 4'd1, 4'd9} : {s[7:4], s[3:0] - 4'd1};
        end
        return {m, s};
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d = state_q;
        set_d   = set_time;
        cnt_d   = count_time;
        presc_d = presc_q;
        acnt_d  = acnt_q;
        case (state_q)
            S_SET: begin
                presc_d = '0;
                acnt_d  = '0;
                if (clear_pe) begin
                    set_d = 16'h0000;
                end else if (start_stop_pe) begin
                    if (set_time != 16'h0000) begin
                        cnt_d   = set_time;
                        state_d = S_RUN;
                    end
                end else begin
                    if (inc_sec_pe) set_d[7:0]  = bcd_inc_wrap(set_time[7:0], 8'h59);
                    if (inc_min_pe) set_d[15:8] = bcd_inc_wrap(set_time[15:8], MAX_MIN_BCD);
                end
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (clear_pe) begin
                    state_d = S_SET;
                    cnt_d   = 16'h0000;
                end else if (tick) begin
                    // A tick coinciding with start still decrements; reaching zero beats pause.
                    cnt_d = bcd_dec_sec(count_time);
                    if (cnt_d == 16'h0000) begin
                        state_d = S_ALARM;
                        acnt_d  = '0;
                    end else if (start_stop_pe) begin
                        state_d = S_PAUSE;
                    end
                end else if (start_stop_pe) begin
                    state_d = S_PAUSE;
                    presc_d = presc_q;
                end
            end
            S_PAUSE: begin
                if (clear_pe) begin
                    state_d = S_SET;
                    cnt_d   = 16'h0000;
                end else if (start_stop_pe) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (clear_pe || start_stop_pe || alarm_ack) begin
                    state_d = S_SET;
                    acnt_d  = '0;
                end else if (tick) begin
                    if (acnt_q == ALARM_LAST) begin
                        state_d = S_SET;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_SET;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= S_SET;
            set_time   <= 16'h0000;
            count_time <= 16'h0000;
            presc_q    <= '0;
            acnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state_q    <= state_d;
            set_time   <= set_d;
            count_time <= cnt_d;
            presc_q    <= presc_d;
            acnt_q     <= acnt_d;
        end
    end

    assign state = state_q;
    assign alarm = (state_q == S_ALARM);
    assign value = (state_q == S_SET) ? set_time : count_time;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with a 10-cycle second and 3-second alarm.
module tb_bcd_countdown_timer;

    localparam int CPS = 10;
    localparam int MXM = 99;
    localparam int ALS = 3;

    localparam logic [4:0] P_START = 5'b00001;
    localparam logic [4:0] P_SEC   = 5'b00010;
    localparam logic [4:0] P_MIN   = 5'b00100;
    localparam logic [4:0] P_CLR   = 5'b01000;
    localparam logic [4:0] P_ACK   = 5'b10000;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        start_stop_pe = 1'b0;
    logic        inc_sec_pe = 1'b0;
    logic        inc_min_pe = 1'b0;
    logic        clear_pe = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [15:0] set_time, count_time, value;
    logic [1:0]  state;
    logic        alarm;
    logic [50:0] obs;

    typedef struct {
        string       name;
        logic [50:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.CLK_PER_SEC(CPS), .MAX_MIN(MXM), .ALARM_SEC(ALS)) dut (
        .clk(clk), .reset_p(reset_p), .start_stop_pe(start_stop_pe),
        .inc_sec_pe(inc_sec_pe), .inc_min_pe(inc_min_pe), .clear_pe(clear_pe),
        .alarm_ack(alarm_ack), .set_time(set_time), .count_time(count_time),
        .value(value), .state(state), .alarm(alarm)
    );

    assign obs = {state, alarm, set_time, count_time, value};

    // Expected snapshot: alarm follows ALARM state, display shows set_time only in SET.
    function automatic exp_t mk(input string name, input logic [1:0] st,
                                input logic [15:0] set_v, input logic [15:0] cnt_v);
        exp_t r;
        r.name = name;
        r.v    = {st, (st == 2'd3), set_v, cnt_v, (st == 2'd0) ? set_v : cnt_v};
        return r;
    endfunction

    // Called at a negedge; the pulse is captured by the following posedge.
    task automatic pulse(input logic [4:0] m);
        {alarm_ack, clear_pe, inc_min_pe, inc_sec_pe, start_stop_pe} = m;
        @(negedge clk);
        {alarm_ack, clear_pe, inc_min_pe, inc_sec_pe, start_stop_pe} = 5'b00000;
    endtask

    task automatic pulses(input logic [4:0] m, input int n);
        repeat (n) pulse(m);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        sb.push_back(mk("reset_state", 2'd0, 16'h0000, 16'h0000));
        @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        reset_p = 1'b0;
        sb.push_back(mk("reset_idle", 2'd0, 16'h0000, 16'h0000));
        cycles(2);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_set;
        sb.push_back(mk("set_0205", 2'd0, 16'h0205, 16'h0000));
        pulses(P_MIN, 2);
        pulses(P_SEC, 5);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("set_clear", 2'd0, 16'h0000, 16'h0000));
        pulse(P_CLR);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_wrap;
        sb.push_back(mk("sec_59", 2'd0, 16'h0359, 16'h0000));
        pulses(P_MIN, 3);
        pulses(P_SEC, 59);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("sec_wrap", 2'd0, 16'h0300, 16'h0000));
        pulse(P_SEC);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("min_99", 2'd0, 16'h9900, 16'h0000));
        pulse(P_CLR);
        pulses(P_MIN, 99);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("min_wrap", 2'd0, 16'h0000, 16'h0000));
        pulse(P_MIN);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_priority;
        sb.push_back(mk("clr_over_start", 2'd0, 16'h0000, 16'h0000));
        pulse(P_SEC);
        pulse(P_CLR | P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("start_zero_ignored", 2'd0, 16'h0000, 16'h0000));
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("start_over_inc", 2'd1, 16'h0001, 16'h0001));
        pulse(P_SEC);
        pulse(P_START | P_SEC);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("run_clear", 2'd0, 16'h0001, 16'h0000));
        pulse(P_CLR);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_alarm;
        sb.push_back(mk("run_0001", 2'd1, 16'h0001, 16'h0001));
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("pre_tick", 2'd1, 16'h0001, 16'h0001));
        cycles(CPS - 1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_on", 2'd3, 16'h0001, 16'h0000));
        cycles(1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_hold", 2'd3, 16'h0001, 16'h0000));
        cycles(CPS * ALS - 1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_timeout", 2'd0, 16'h0001, 16'h0000));
        cycles(1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_borrow;
        sb.push_back(mk("run_0100", 2'd1, 16'h0100, 16'h0100));
        pulse(P_CLR);
        pulse(P_MIN);
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("borrow_0059", 2'd1, 16'h0100, 16'h0059));
        cycles(CPS);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("dec_0058", 2'd1, 16'h0100, 16'h0058));
        cycles(CPS);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("clear_keeps_set", 2'd0, 16'h0100, 16'h0000));
        pulse(P_CLR);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    // Pause after 3 prescaler counts, so 7 cycles remain after resuming.
    task automatic test_pause;
        sb.push_back(mk("pause", 2'd2, 16'h0005, 16'h0005));
        pulse(P_CLR);
        pulses(P_SEC, 5);
        pulse(P_START);
        cycles(3);
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("pause_hold_inc_ignored", 2'd2, 16'h0005, 16'h0005));
        pulse(P_SEC);
        pulse(P_MIN);
        cycles(48);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("resume_pre_tick", 2'd1, 16'h0005, 16'h0005));
        pulse(P_START);
        cycles(CPS - 3 - 1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("resume_tick", 2'd1, 16'h0005, 16'h0004));
        cycles(1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    task automatic test_back_to_back;
        sb.push_back(mk("tick_and_pause", 2'd2, 16'h0005, 16'h0003));
        cycles(CPS - 1);
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("resume2_pre_tick", 2'd1, 16'h0005, 16'h0003));
        pulse(P_START);
        cycles(CPS - 1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("resume2_tick", 2'd1, 16'h0005, 16'h0002));
        cycles(1);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("dec_0001", 2'd1, 16'h0005, 16'h0001));
        cycles(CPS);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_beats_pause", 2'd3, 16'h0005, 16'h0000));
        cycles(CPS - 1);
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_ack", 2'd0, 16'h0005, 16'h0000));
        pulse(P_ACK);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    // Reset is raised between clock edges and sampled before the next posedge.
    task automatic test_async_reset;
        sb.push_back(mk("reset_mid_run", 2'd0, 16'h0000, 16'h0000));
        pulse(P_CLR);
        pulses(P_SEC, 3);
        pulse(P_START);
        cycles(4);
        #2 reset_p = 1'b1;
        #1;
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        @(negedge clk);
        reset_p = 1'b0;
        sb.push_back(mk("start_after_reset_ignored", 2'd0, 16'h0000, 16'h0000));
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("pulse_after_reset", 2'd0, 16'h0001, 16'h0000));
        pulse(P_SEC);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("alarm_before_reset", 2'd3, 16'h0001, 16'h0000));
        pulse(P_START);
        cycles(CPS);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        sb.push_back(mk("reset_mid_alarm", 2'd0, 16'h0000, 16'h0000));
        cycles(5);
        #2 reset_p = 1'b1;
        #1;
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
        @(negedge clk);
        reset_p = 1'b0;
        sb.push_back(mk("start_after_reset2_ignored", 2'd0, 16'h0000, 16'h0000));
        pulse(P_START);
        e = sb.pop_front(); n_total++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_set;
        test_wrap;
        test_priority;
        test_alarm;
        test_borrow;
        test_pause;
        test_back_to_back;
        test_async_reset;
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
